// File: rtl/pipe_cu_if.sv
// pipe_cu_if: bundle between the datapath and the pipeline control unit.
//   ID inputs : op, func, rs, rt, rd, rsrtequ
//   ID outputs: wpcir, pcsource, sext, regrt, fwda, fwdb
//   EX outputs: ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern
//   MEM outputs: mwreg, mm2reg, mwmem, mrn
//   WB outputs: wwreg, wm2reg, wrn
// master = datapath side, slave = control unit.
interface pipe_cu_if #(
    parameter int RW = 5
);
    logic [5:0]    op;
    logic [5:0]    func;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          rsrtequ;

    logic          wpcir;
    logic [1:0]    pcsource;
    logic          sext;
    logic          regrt;
    logic [1:0]    fwda;
    logic [1:0]    fwdb;

    logic          ewreg;
    logic          em2reg;
    logic          ewmem;
    logic          ejal;
    logic          ealuimm;
    logic          eshift;
    logic [3:0]    ealuc;
    logic [RW-1:0] ern;

    logic          mwreg;
    logic          mm2reg;
    logic          mwmem;
    logic [RW-1:0] mrn;

    logic          wwreg;
    logic          wm2reg;
    logic [RW-1:0] wrn;

    modport master (
        output op, func, rs, rt, rd, rsrtequ,
        input  wpcir, pcsource, sext, regrt, fwda, fwdb,
        input  ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern,
        input  mwreg, mm2reg, mwmem, mrn,
        input  wwreg, wm2reg, wrn
    );

    modport slave (
        input  op, func, rs, rt, rd, rsrtequ,
        output wpcir, pcsource, sext, regrt, fwda, fwdb,
        output ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern,
        output mwreg, mm2reg, mwmem, mrn,
        output wwreg, wm2reg, wrn
    );
endinterface

// File: rtl/pipe_cu.sv
// pipe_cu: control unit for a five-stage MIPS-subset pipeline.
// Decodes the ID instruction, resolves branches in ID, generates operand
// forwarding selects and stalls, and carries controls through ID/EX,
// EX/MEM and MEM/WB registers.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   cu     : pipe_cu_if.slave (ID fields in, ID/EX/MEM/WB controls out)
// FWD=1: forwarding with a single load-use stall; FWD=0: stall on every RAW.
module pipe_cu #(
    parameter int RW  = 5,
    parameter int FWD = 1
) (
    input  logic     clock,
    input  logic     resetn,
    pipe_cu_if.slave cu
);
    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic          jal;
        logic          aluimm;
        logic          shift;
        logic [3:0]    aluc;
        logic [RW-1:0] rn;
    } ex_t;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic          wmem;
        logic [RW-1:0] rn;
    } mem_t;

    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic [RW-1:0] rn;
    } wb_t;

    ex_t  ex_d, ex_q;
    mem_t mem_q;
    wb_t  wb_q;

    logic r_type;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
    logic use_rs, use_rt, rs_nz, rt_nz;
    logic stall;

    assign r_type = (cu.op == 6'b000000);
    assign i_add  = r_type & (cu.func == 6'b100000);
    assign i_sub  = r_type & (cu.func == 6'b100010);
    assign i_and  = r_type & (cu.func == 6'b100100);
    assign i_or   = r_type & (cu.func == 6'b100101);
    assign i_xor  = r_type & (cu.func == 6'b100110);
    assign i_sll  = r_type & (cu.func == 6'b000000);
    assign i_srl  = r_type & (cu.func == 6'b000010);
    assign i_sra  = r_type & (cu.func == 6'b000011);
    assign i_jr   = r_type & (cu.func == 6'b001000);
    assign i_addi = (cu.op == 6'b001000);
    assign i_andi = (cu.op == 6'b001100);
    assign i_ori  = (cu.op == 6'b001101);
    assign i_xori = (cu.op == 6'b001110);
    assign i_lw   = (cu.op == 6'b100011);
    assign i_sw   = (cu.op == 6'b101011);
    assign i_beq  = (cu.op == 6'b000100);
    assign i_bne  = (cu.op == 6'b000101);
    assign i_lui  = (cu.op == 6'b001111);
    assign i_j    = (cu.op == 6'b000010);
    assign i_jal  = (cu.op == 6'b000011);

    assign use_rs = i_add | i_sub | i_and | i_or | i_xor | i_jr | i_addi | i_andi |
                    i_ori | i_xori | i_lw | i_sw | i_beq | i_bne;
    assign use_rt = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                    i_sw | i_beq | i_bne;
    assign rs_nz  = (cu.rs != '0);
    assign rt_nz  = (cu.rt != '0);

    // ID decode into the EX-bound control word
    always_comb begin
        ex_d        = '0;
        ex_d.aluc[3] = i_sra;
        ex_d.aluc[2] = i_sub | i_or | i_srl | i_sra | i_ori | i_lui;
        ex_d.aluc[1] = i_xor | i_sll | i_srl | i_sra | i_xori | i_beq | i_bne | i_lui;
        ex_d.aluc[0] = i_and | i_or | i_sll | i_srl | i_sra | i_andi | i_ori;
        ex_d.shift  = i_sll | i_srl | i_sra;
        ex_d.aluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
        ex_d.wreg   = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                      i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_jal;
        ex_d.m2reg  = i_lw;
        ex_d.wmem   = i_sw;
        ex_d.jal    = i_jal;
        if (i_jal)
            ex_d.rn = '1;
        else if (cu.regrt)
            ex_d.rn = cu.rt;
        else
            ex_d.rn = cu.rd;
    end

    assign cu.sext  = i_addi | i_lw | i_sw | i_beq | i_bne;
    assign cu.regrt = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
    assign cu.pcsource[1] = i_jr | i_j | i_jal;
    assign cu.pcsource[0] = (i_beq & cu.rsrtequ) | (i_bne & ~cu.rsrtequ) | i_j | i_jal;

    // Hazard detection and forwarding; r0 never matches
    always_comb begin
        cu.fwda = 2'b00;
        cu.fwdb = 2'b00;
        stall   = 1'b0;
        if (FWD != 0) begin
            if (ex_q.wreg & ~ex_q.m2reg & rs_nz & (ex_q.rn == cu.rs))
                cu.fwda = 2'b01;
            else if (mem_q.wreg & mem_q.m2reg & rs_nz & (mem_q.rn == cu.rs))
                cu.fwda = 2'b11;
            else if (mem_q.wreg & rs_nz & (mem_q.rn == cu.rs))
                cu.fwda = 2'b10;

            if (ex_q.wreg & ~ex_q.m2reg & rt_nz & (ex_q.rn == cu.rt))
                cu.fwdb = 2'b01;
            else if (mem_q.wreg & mem_q.m2reg & rt_nz & (mem_q.rn == cu.rt))
                cu.fwdb = 2'b11;
            else if (mem_q.wreg & rt_nz & (mem_q.rn == cu.rt))
                cu.fwdb = 2'b10;

            stall = ex_q.wreg & ex_q.m2reg & (ex_q.rn != '0) &
                    ((use_rs & (ex_q.rn == cu.rs)) | (use_rt & (ex_q.rn == cu.rt)));
        end else begin
            stall = (ex_q.wreg & (ex_q.rn != '0) &
                     ((use_rs & (ex_q.rn == cu.rs)) | (use_rt & (ex_q.rn == cu.rt)))) |
                    (mem_q.wreg & (mem_q.rn != '0) &
                     ((use_rs & (mem_q.rn == cu.rs)) | (use_rt & (mem_q.rn == cu.rt))));
        end
    end

    assign cu.wpcir = ~stall;

    // A stall inserts a bubble into EX while the ID instruction is held
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q        <= stall ? '0 : ex_d;
            mem_q.wreg  <= ex_q.wreg;
            mem_q.m2reg <= ex_q.m2reg;
            mem_q.wmem  <= ex_q.wmem;
            mem_q.rn    <= ex_q.rn;
            wb_q.wreg   <= mem_q.wreg;
            wb_q.m2reg  <= mem_q.m2reg;
            wb_q.rn     <= mem_q.rn;
        end
    end

    assign cu.ewreg   = ex_q.wreg;
    assign cu.em2reg  = ex_q.m2reg;
    assign cu.ewmem   = ex_q.wmem;
    assign cu.ejal    = ex_q.jal;
    assign cu.ealuimm = ex_q.aluimm;
    assign cu.eshift  = ex_q.shift;
    assign cu.ealuc   = ex_q.aluc;
    assign cu.ern     = ex_q.rn;
    assign cu.mwreg   = mem_q.wreg;
    assign cu.mm2reg  = mem_q.m2reg;
    assign cu.mwmem   = mem_q.wmem;
    assign cu.mrn     = mem_q.rn;
    assign cu.wwreg   = wb_q.wreg;
    assign cu.wm2reg  = wb_q.m2reg;
    assign cu.wrn     = wb_q.rn;
endmodule
